// File: rtl/calc_disp_pkg.sv
// Shared constants, types and the ones'-complement conversion for calc_result_display.
package calc_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_MINUS = 7'b1000000;

  // Segment order gfedcba, active-high; entry 0 is the rightmost element.
  localparam logic [7:0][6:0] SEG_DIGIT = {
    7'b0000111,  // 7
    7'b1111101,  // 6
    7'b1101101,  // 5
    7'b1100110,  // 4
    7'b1001111,  // 3
    7'b1011011,  // 2
    7'b0000110,  // 1
    7'b0111111   // 0
  };

  typedef enum logic {
    IDLE,
    SHOW
  } state_t;

  typedef enum logic {
    DIG_MAG,
    DIG_SIGN
  } digit_t;

  typedef struct packed {
    logic       neg;
    logic [2:0] mag;
  } sign_mag_t;

  // Negative zero (4'b1111) folds onto plain zero so no minus sign is ever shown for it.
  function automatic sign_mag_t to_sign_mag(input logic [3:0] r);
    sign_mag_t s;
    s.neg = r[3];
    s.mag = r[3] ? ~r[2:0] : r[2:0];
    if (s.mag == 3'd0) s.neg = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/calc_result_display_seg7_decode.sv
// Combinational 3-bit magnitude to 7-segment (gfedcba) pattern decoder.
module seg7_decode
  import calc_disp_pkg::*;
(
  input  logic [2:0] mag,
  output logic [6:0] seg
);

  assign seg = SEG_DIGIT[mag];

endmodule

// File: rtl/calc_result_display.sv
// Two-digit multiplexed display of a ones'-complement adder result.
// Optional negative-result blinking is enabled with `define CALC_DISP_BLINK_NEG_EN.
module calc_result_display
  import calc_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 16,
  parameter int BLINK_DIV   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] result,
  input  logic       result_valid,
  input  logic       clear,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       disp_updated
);

  localparam int             CNT_W   = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  state_t           state, state_n;
  digit_t           digit, digit_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       mag, mag_n;
  logic             neg, neg_n;
  logic             valid_q, armed;
  logic             capture, wrap, blank_n;
  logic [6:0]       mag_seg, seg_n;
  logic [1:0]       an_n;

  // armed stays low until result_valid is seen low, so a level already high at reset release is ignored.
  assign capture = result_valid & ~valid_q & armed & ~clear;
  assign wrap    = (state == SHOW) && (cnt == CNT_MAX);

  // NOTE: every combinational output gets a default first so no latch is inferred on untaken branches.
  always_comb begin
    state_n = state;
    digit_n = digit;
    cnt_n   = cnt;
    mag_n   = mag;
    neg_n   = neg;
    if (clear) begin
      state_n = IDLE;
      digit_n = DIG_MAG;
      cnt_n   = '0;
    end else begin
      if (state == SHOW) begin
        cnt_n = wrap ? '0 : cnt + CNT_W'(1);
        if (wrap) digit_n = (digit == DIG_MAG) ? DIG_SIGN : DIG_MAG;
      end
      if (capture) begin
        state_n        = SHOW;
        {neg_n, mag_n} = to_sign_mag(result);
      end
    end
  end

`ifdef CALC_DISP_BLINK_NEG_EN
  localparam int             BLK_W    = $clog2(2 * BLINK_DIV);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(2 * BLINK_DIV - 1);

  logic [BLK_W-1:0] blink, blink_n;

  // Counts refresh periods; the upper half of its range is the blanked half-phase.
  always_comb begin
    blink_n = blink;
    if (clear || capture) blink_n = '0;
    else if (wrap)        blink_n = (blink == BLK_LAST) ? '0 : blink + BLK_W'(1);
    blank_n = neg_n && (blink_n >= BLK_W'(BLINK_DIV));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) blink <= '0;
    else     blink <= blink_n;
  end
`else
  assign blank_n = 1'b0;
`endif

  seg7_decode u_seg7_decode (
    .mag (mag_n),
    .seg (mag_seg)
  );

  // Outputs are registered from next-state values so they change together with disp_updated.
  always_comb begin
    an_n  = 2'b11;
    seg_n = SEG_BLANK;
    if (state_n == SHOW && !blank_n) begin
      if (digit_n == DIG_MAG) begin
        an_n  = 2'b10;
        seg_n = mag_seg;
      end else begin
        an_n  = 2'b01;
        seg_n = neg_n ? SEG_MINUS : SEG_BLANK;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      digit        <= DIG_MAG;
      cnt          <= '0;
      mag          <= '0;
      neg          <= 1'b0;
      valid_q      <= 1'b0;
      armed        <= 1'b0;
      seg          <= SEG_BLANK;
      an           <= 2'b11;
      disp_updated <= 1'b0;
    end else begin
      state        <= state_n;
      digit        <= digit_n;
      cnt          <= cnt_n;
      mag          <= mag_n;
      neg          <= neg_n;
      valid_q      <= result_valid;
      armed        <= armed | ~result_valid;
      seg          <= seg_n;
      an           <= an_n;
      disp_updated <= capture;
    end
  end

endmodule
